// File: rtl/matrix_op_sequencer.sv
// Element-wise add/subtract sequencer over two operand matrices held in a registered-read memory.
// Define MATRIX_SAT_EN to saturate results instead of wrapping them.
module matrix_op_sequencer #(
   parameter int DATA_W = 8,
   parameter int N_ELEM = 4,
   localparam int AW = $clog2(N_ELEM)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [2:0]        opcode,
   input  logic              is_op,
   input  logic              is_result,
   output logic [AW-1:0]     rd_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic [DATA_W-1:0] b_data,
   output logic              wr_en,
   output logic [AW-1:0]     wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [2:0]        last_op
);

   localparam logic [2:0]    OP_ADD   = 3'b001;
   localparam logic [2:0]    OP_SUB   = 3'b010;
   localparam logic [AW-1:0] IDX_LAST = AW'(N_ELEM - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [AW-1:0]     idx_q;
   logic              is_op_dly_q;
   logic              s1_valid_q;
   logic [AW-1:0]     s1_addr_q;
   logic              busy_q;
   logic              done_q;
   logic              ovf_q;
   logic [2:0]        last_op_q;

   logic              start;
   logic              is_sub;
   logic [DATA_W:0]   sum_w;
   logic [DATA_W:0]   diff_w;
   logic              flow_d;
   logic [DATA_W-1:0] result_d;

   assign start = is_op & ~is_op_dly_q & is_result &
                  ((opcode == OP_ADD) | (opcode == OP_SUB));

   // One extra bit catches the carry on add and the borrow (a < b) on subtract.
   assign is_sub = (last_op_q == OP_SUB);
   assign sum_w  = {1'b0, a_data} + {1'b0, b_data};
   assign diff_w = {1'b0, a_data} - {1'b0, b_data};
   assign flow_d = is_sub ? diff_w[DATA_W] : sum_w[DATA_W];

`ifdef MATRIX_SAT_EN
   always_comb begin
      result_d = is_sub ? diff_w[DATA_W-1:0] : sum_w[DATA_W-1:0];
      if (flow_d) begin
         result_d = is_sub ? '0 : '1;
      end
   end
`else
   assign result_d = is_sub ? diff_w[DATA_W-1:0] : sum_w[DATA_W-1:0];
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         is_op_dly_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         last_op_q   <= '0;
      end else begin
         is_op_dly_q <= is_op;
         s1_valid_q  <= (state_q == S_RUN);
         s1_addr_q   <= (state_q == S_RUN) ? idx_q : '0;
         done_q      <= 1'b0;

         if (s1_valid_q && flow_d) begin
            ovf_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  last_op_q <= opcode;
                  ovf_q     <= 1'b0;
                  idx_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= S_RUN;
               end
            end
            S_RUN: begin
               // idx_q doubles as rd_addr, so it is parked at 0 when leaving RUN.
               if (idx_q == IDX_LAST) begin
                  idx_q   <= '0;
                  state_q <= S_DRAIN;
               end else begin
                  idx_q <= idx_q + AW'(1);
               end
            end
            S_DRAIN: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_addr  = idx_q;
   assign wr_en    = s1_valid_q;
   assign wr_addr  = s1_addr_q;
   assign wr_data  = s1_valid_q ? result_d : '0;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign last_op  = last_op_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Self-checking bench: timeline-based reference model plus literal checks from the worked examples.
module tb_matrix_op_sequencer;

   localparam int DATA_W = 8;
   localparam int N      = 4;
   localparam int AW     = 2;
`ifdef MATRIX_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              nrst;
   logic [2:0]        opcode;
   logic              is_op;
   logic              is_result;
   logic [AW-1:0]     rd_addr;
   logic [DATA_W-1:0] a_data;
   logic [DATA_W-1:0] b_data;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [2:0]        last_op;

   matrix_op_sequencer #(.DATA_W(DATA_W), .N_ELEM(N)) dut (
      .clk(clk), .nrst(nrst), .opcode(opcode), .is_op(is_op), .is_result(is_result),
      .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .overflow(overflow), .last_op(last_op)
   );

   always #5 clk = ~clk;

   // Operand memory with one cycle of read latency.
   logic [DATA_W-1:0] mem_a [N];
   logic [DATA_W-1:0] mem_b [N];
   always @(posedge clk) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
   end

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   int m_t_start = -1000;
   bit m_prev = 1'b0;
   bit m_ovf  = 1'b0;
   int m_last = 0;
   int cap_data [N];
   int cap_cnt  = 0;
   int done_cnt = 0;
   int op_num   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void elem_op(input int op, input int a, input int b,
                                   output int r, output bit c);
      int s;
      if (op == 1) begin
         s = a + b;
         c = (s > 255);
         r = c ? (SAT ? 255 : s - 256) : s;
      end else begin
         c = (a < b);
         r = c ? (SAT ? 0 : a - b + 256) : a - b;
      end
   endfunction

   function automatic bit model_idle();
      return (cyc - m_t_start) >= N + 3;
   endfunction

   // Reference: each output is a function of the cycle offset from the accepted request.
   always @(negedge clk) begin
      int rel, exp_rd, exp_wa, exp_wd;
      bit exp_busy, exp_wr, exp_done, c;
      if (!nrst) begin
         chk("rst_rd_addr", rd_addr, 0);
         chk("rst_wr_en", wr_en, 0);
         chk("rst_wr_addr", wr_addr, 0);
         chk("rst_wr_data", wr_data, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_overflow", overflow, 0);
         chk("rst_last_op", last_op, 0);
         m_t_start = -1000;
         m_prev    = 1'b0;
         m_ovf     = 1'b0;
         m_last    = 0;
      end else begin
         rel      = cyc - m_t_start;
         exp_busy = (rel >= 1) && (rel <= N + 1);
         exp_rd   = ((rel >= 1) && (rel <= N)) ? rel - 1 : 0;
         exp_wr   = (rel >= 2) && (rel <= N + 1);
         exp_done = (rel == N + 2);
         exp_wa   = 0;
         exp_wd   = 0;
         c        = 1'b0;
         if (exp_wr) begin
            exp_wa = rel - 2;
            elem_op(m_last, int'(mem_a[exp_wa]), int'(mem_b[exp_wa]), exp_wd, c);
         end
         chk("rd_addr", rd_addr, exp_rd);
         chk("busy", busy, exp_busy);
         chk("wr_en", wr_en, exp_wr);
         chk("wr_addr", wr_addr, exp_wa);
         chk("wr_data", wr_data, exp_wd);
         chk("done", done, exp_done);
         chk("overflow", overflow, m_ovf);
         chk("last_op", last_op, m_last);
         if (wr_en) begin
            cap_data[wr_addr] = int'(wr_data);
            cap_cnt++;
         end
         if (done) begin
            done_cnt++;
            op_num++;
            $display("op %0d: opcode=%0d overflow=%0b cycle=%0d", op_num, last_op, overflow, cyc);
         end
         if (c) m_ovf = 1'b1;
         if (is_op && !m_prev && is_result && (opcode == 3'd1 || opcode == 3'd2) && model_idle()) begin
            m_t_start = cyc;
            m_ovf     = 1'b0;
            m_last    = int'(opcode);
         end
         m_prev = is_op;
      end
      cyc++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input int a0, a1, a2, a3, b0, b1, b2, b3);
      mem_a[0] = 8'(a0); mem_a[1] = 8'(a1); mem_a[2] = 8'(a2); mem_a[3] = 8'(a3);
      mem_b[0] = 8'(b0); mem_b[1] = 8'(b1); mem_b[2] = 8'(b2); mem_b[3] = 8'(b3);
   endtask

   task automatic clear_cap();
      for (int i = 0; i < N; i++) cap_data[i] = -1;
      cap_cnt  = 0;
      done_cnt = 0;
   endtask

   task automatic req(input int op, input bit res);
      step(1);
      is_op = 1'b1; is_result = res; opcode = 3'(op);
      step(1);
      is_op = 1'b0; is_result = 1'b0; opcode = 3'd0;
   endtask

   initial begin
      nrst = 1'b0; is_op = 1'b0; is_result = 1'b0; opcode = 3'd0;
      set_mem(0, 0, 0, 0, 0, 0, 0, 0);
      clear_cap();
      step(3);
      nrst = 1'b1;

      // Plain add
      set_mem(1, 2, 3, 4, 10, 20, 30, 40);
      req(1, 1'b1);
      step(8);
      chk("add_count", cap_cnt, 4);
      chk("add_d0", cap_data[0], 11);
      chk("add_d1", cap_data[1], 22);
      chk("add_d2", cap_data[2], 33);
      chk("add_d3", cap_data[3], 44);
      chk("add_done", done_cnt, 1);
      chk("add_ovf", overflow, 0);
      chk("add_last_op", last_op, 1);

      // Add with carry
      clear_cap();
      set_mem(200, 2, 3, 4, 100, 20, 30, 40);
      req(1, 1'b1);
      step(8);
      chk("carry_d0", cap_data[0], SAT ? 255 : 44);
      chk("carry_ovf", overflow, 1);

      // Subtract with borrow
      clear_cap();
      set_mem(9, 5, 7, 0, 1, 9, 7, 0);
      req(2, 1'b1);
      step(8);
      chk("sub_d0", cap_data[0], 8);
      chk("sub_d1", cap_data[1], SAT ? 0 : 252);
      chk("sub_d2", cap_data[2], 0);
      chk("sub_ovf", overflow, 1);
      chk("sub_last_op", last_op, 2);

      // Rejected requests: bad opcode, unqualified edge
      clear_cap();
      req(3, 1'b1);
      step(3);
      req(1, 1'b0);
      step(8);
      chk("reject_writes", cap_cnt, 0);
      chk("reject_done", done_cnt, 0);
      chk("reject_last_op", last_op, 2);

      // Extra edges during RUN and DONE are dropped
      clear_cap();
      set_mem(1, 2, 3, 4, 10, 20, 30, 40);
      is_op = 1'b1; is_result = 1'b1; opcode = 3'd1;
      step(1); is_op = 1'b0;
      step(1); is_op = 1'b1; opcode = 3'd2;
      step(1); is_op = 1'b0;
      step(3); is_op = 1'b1;
      step(1); is_op = 1'b0; is_result = 1'b0; opcode = 3'd0;
      step(10);
      chk("busy_req_writes", cap_cnt, 4);
      chk("busy_req_done", done_cnt, 1);
      chk("busy_req_last_op", last_op, 1);

      // Held level: one operation; fall then rise gives a second with overflow cleared
      clear_cap();
      set_mem(200, 2, 3, 4, 100, 20, 30, 40);
      is_op = 1'b1; is_result = 1'b1; opcode = 3'd1;
      step(10);
      chk("held_ovf1", overflow, 1);
      set_mem(1, 2, 3, 4, 10, 20, 30, 40);
      step(10);
      chk("held_done", done_cnt, 1);
      is_op = 1'b0;
      step(1);
      is_op = 1'b1;
      step(1);
      is_op = 1'b0; is_result = 1'b0; opcode = 3'd0;
      step(8);
      chk("held_done2", done_cnt, 2);
      chk("held_ovf2", overflow, 0);

      // Reset mid-operation
      clear_cap();
      req(1, 1'b1);
      step(2);
      nrst = 1'b0;
      step(2);
      nrst = 1'b1;
      clear_cap();
      step(8);
      chk("abort_writes", cap_cnt, 0);
      chk("abort_done", done_cnt, 0);
      req(1, 1'b1);
      step(8);
      chk("after_rst_count", cap_cnt, 4);
      chk("after_rst_d3", cap_data[3], 44);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(1);
         if (model_idle()) begin
            for (int k = 0; k < N; k++) begin
               mem_a[k] = 8'($urandom_range(0, 255));
               mem_b[k] = 8'($urandom_range(0, 255));
            end
         end
         is_op     = 1'($urandom_range(0, 1));
         is_result = ($urandom_range(0, 3) != 0);
         opcode    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                 : 3'($urandom_range(1, 2));
         nrst      = ($urandom_range(0, 99) != 0);
      end
      nrst = 1'b1; is_op = 1'b0;
      step(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/matrix_op_sequencer.md
# matrix_op_sequencer

Downstream consumer of the opcode encoder in the matrix calculator datapath. Detects a new operation request (`is_op` rising edge qualified by `is_result`) and latches the 3-bit opcode. It then walks every element of the A and B operand matrices through a registered-read operand memory, computes the element-wise add or subtract, and writes each result to the result matrix. A one-cycle `done` pulse marks completion, and a sticky `overflow` flag reports any carry or borrow during the operation.

## Interface
- `DATA_W`, default 8: element width in bits, unsigned.
- `N_ELEM`, default 4: elements per matrix (2x2). Must be ≥2. `AW = $clog2(N_ELEM)`.

- `clk` input 1: clock, rising edge.
- `nrst` input 1: reset, asynchronous, active-low.
- `opcode` input 3: opcode from the encoder. 3'b001 = add, 3'b010 = subtract; all other values are invalid.
- `is_op` input 1: operation-request level from the encoder.
- `is_result` input 1: qualifier; a request is accepted only when this is 1 in the same cycle.
- `rd_addr` output AW: element index presented to the operand memory.
- `a_data` input DATA_W: A element; valid one cycle after `rd_addr`.
- `b_data` input DATA_W: B element; valid one cycle after `rd_addr`.
- `wr_en` output 1: result write strobe.
- `wr_addr` output AW: result element index.
- `wr_data` output DATA_W: result element value. Forced to 0 when `wr_en` = 0.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle completion pulse.
- `overflow` output 1: sticky carry/borrow flag for the last operation.
- `last_op` output 3: opcode of the last accepted operation.

## Operation
- **Edge detect.** The `is_op_d` register is updated every cycle in every state. `start = is_op & ~is_op_d & is_result & (opcode ∈ {001, 010})`.
- **States.** IDLE → RUN → DRAIN → DONE → IDLE.
- **IDLE.** On `start`:
  - latch `opcode` into `last_op`;
  - clear `overflow`;
  - set `idx` = 0;
  - go to RUN.
- **RUN.** `rd_addr = idx`; `idx` increments each cycle. When `idx` = N_ELEM−1, go to DRAIN.
- **DRAIN.** One cycle so the final read returns. Go to DONE.
- **DONE.** `done` = 1 for one cycle, then go to IDLE.
- **Pipeline stage s1.** `s1_valid` and `s1_addr` are `idx` delayed one cycle, and s1 is valid only for reads issued in RUN. When `s1_valid` = 1:
  - `wr_en` = 1;
  - `wr_addr` = `s1_addr`;
  - `wr_data` = f(`a_data`, `b_data`), combinational from the s1 registers and the memory data.
- **Arithmetic.** Computed at DATA_W+1 bits.
  - Add: carry is bit DATA_W.
  - Subtract: borrow when `a_data < b_data`.
  - Carry or borrow sets `overflow`. It stays set until the next accepted `start` or reset.
- **`busy`.** 1 in RUN and DRAIN; 0 in IDLE and DONE.
- **`rd_addr`.** 0 outside RUN.
- **Invalid opcode or `is_result` = 0 at the edge.** Request ignored; no state change. A held `is_op` does not retrigger later.
- **Request while not IDLE.** Ignored and not queued, including a request during DONE.
- **Reset.** All state returns to IDLE with every output at 0: `rd_addr`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`, `overflow`, `last_op`. Also `is_op_d` = 0 and `s1_valid` = 0. A reset mid-operation aborts with no further writes.

## Timing
- Cycle T: `start` sampled high in IDLE.
- T+1 … T+N_ELEM: RUN, `rd_addr` = 0 … N_ELEM−1, `busy` = 1.
- T+2 … T+N_ELEM+1: `wr_en` = 1 with `wr_addr` = 0 … N_ELEM−1, back-to-back with no gaps. The last write falls in DRAIN (T+N_ELEM+1).
- T+N_ELEM+2: `done` = 1, `busy` = 0. `overflow` is final and stable from this cycle.
- T+N_ELEM+3: IDLE. The earliest next `start` is sampled in this cycle.
- Default N_ELEM = 4:
  - `busy` T+1..T+5;
  - writes T+2..T+5;
  - `done` T+6;
  - total 6 cycles from the accepting edge to `done`.

## Configuration
- `MATRIX_SAT_EN`
  - **Defined.** Add saturates to 2^DATA_W−1; subtract clamps to 0. `overflow` is still set on saturation.
  - **Undefined.** Results wrap modulo 2^DATA_W. `overflow` is set identically.

## Test plan
- **Add.** A = {1, 2, 3, 4}, B = {10, 20, 30, 40}, opcode 001, `is_op` rises with `is_result` = 1 → writes {11, 22, 33, 44} at addr 0..3 on T+2..T+5, `done` at T+6, `overflow` = 0, `last_op` = 001.
- **Overflow.** A[0] = 200, B[0] = 100, add → `wr_data` = 44 with `overflow` = 1 (wrap); 255 with MATRIX_SAT_EN. Subtract A[1] = 5, B[1] = 9 → 252 (wrap) or 0 (sat), `overflow` = 1.
- **Rejected requests.** opcode 011, or `is_result` = 0, or a second `is_op` edge during RUN/DONE → no writes, `busy` stays 0 (or the current op completes unaltered with exactly 4 writes).
- **Held level.** `is_op` held high for 20 cycles → exactly one operation, one `done`. Falling then rising again → a second operation, with `overflow` cleared at its start.
- **Reset mid-operation.** `nrst` low at T+3 → all outputs 0 immediately, no writes after the reset is released, IDLE. A new request afterwards behaves as the Add case.
